ofmap_stream_collector: RTL
===========================

// Module: ofmap_stream_collector
// PURPOSE
//  Collects N_CH-wide parallel feature-map results from the conv core (valid + sof, one vector
//  per output pixel) into a DEPTH-entry FIFO. Re-emits them as one DATA_W word per cycle on a
//  ready/valid stream, tagged with channel index, pixel (x,y), sof/eol/eof. Sits between core
//  output and DMA/writeback; replaces fixed 16-channel, 3-column bench-side dump logic.
// PARAMETERS
//  DATA_W  32  bits per channel word
//  N_CH    16  channels per input vector (>=2)
//  DEPTH   4   FIFO depth in vectors (power of 2, >=2)
//  COLS    3   output pixels per row
//  ROWS    3   output rows per frame
//  XY_W    8   width of out_x/out_y (must hold COLS-1, ROWS-1)
// PORTS
//  clk        in   1               clock, all logic on posedge
//  rst        in   1               async reset, ACTIVE-LOW (asserted when 0)
//  in_valid   in   1               input vector valid
//  in_sof     in   1               vector is first pixel of a frame
//  in_data    in   N_CH*DATA_W     channel c at bits [c*DATA_W +: DATA_W]
//  in_ready   out  1               FIFO not full
//  out_valid  out  1               out_* word valid
//  out_ready  in   1               downstream accepts
//  out_data   out  DATA_W          channel word
//  out_ch     out  $clog2(N_CH)    channel index of out_data
//  out_x      out  XY_W            pixel column
//  out_y      out  XY_W            pixel row
//  out_sof    out  1               first word of frame (ch 0, pixel 0,0)
//  out_eol    out  1               last word of a row
//  out_eof    out  1               last word of a frame
//  frame_done out  1               1-cycle pulse after eof word accepted
//  overflow   out  1               sticky: vector offered while in_ready=0
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, ch=0, x=y=0, in_ready=1, out_valid=0, all other outputs 0.
//  Push: in_valid&in_ready stores {in_sof,in_data}. in_ready = !full (registered count, no
//   same-cycle pop bypass). in_valid&!in_ready: vector dropped, overflow<=1 until reset.
//  Latency: vector pushed at edge t -> out_valid=1 from t+1 (if FIFO was empty).
//  Read: out_valid = !empty; out_data = head[ch]; out_ch = ch. Accept = out_valid&out_ready.
//   On accept: ch<N_CH-1 -> ch+1; ch==N_CH-1 -> ch=0, pop head, advance pixel.
//  Stall: out_valid&!out_ready -> every out_* held stable; no word lost or repeated.
//  Coordinates: head with sof flag presents x=y=0 (counters reload). Pixel advance:
//   x<COLS-1 -> x+1; else x=0 and (y<ROWS-1 ? y+1 : y=0).
//  Flags: out_sof = head.sof & ch==0. out_eol = ch==N_CH-1 & x==COLS-1.
//   out_eof = out_eol & y==ROWS-1. Accept of eof word -> frame_done=1 next cycle only.
//  Wrap w/o sof: after eof, next frame starts at (0,0); out_sof=0 unless that vector had in_sof.
//  sof mid-frame: coordinates restart at (0,0); no frame_done for aborted frame.
//  Simultaneous push+pop: both occur; count unchanged; full FIFO refuses push even if pop.
//  Reset mid-operation: FIFO contents discarded; first word after release is next pushed vector.
//  FIFO pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
// TESTING
//  1 Reset: rst=0 mid-stream -> in_ready=1, out_valid=0, overflow=0, frame_done=0 immediately.
//  2 One vector ch c = 0x100+c, sof=1, out_ready=1 -> 16 words 0x100..0x10F, ch 0..15, (0,0),
//    out_sof on word 0 only, out_valid rises 1 cycle after push.
//  3 Frame of 9 vectors, sof on first, out_ready=1 -> 144 words; eol at ch15 of x=2; eof at
//    word 143 (2,2); frame_done pulse exactly 1 cycle after.
//  4 out_ready toggled pseudo-random 50% -> word sequence identical to test 3; out_* stable
//    in every stalled cycle.
//  5 out_ready=0, push 5 vectors with DEPTH=4 -> in_ready=0 after 4; 5th dropped; overflow=1
//    sticky; 64 words drained in order.
//  6 sof on 4th vector of frame -> coords (0,0) on that vector, no frame_done for first 3;
//    re-run with N_CH=8, COLS=4, ROWS=2, DATA_W=16 -> eof on word 63.

Source files
------------

// File: rtl/ofmap_stream_if.sv
// Bundle of the collector's vector input stream, word output stream and status flags.
// Both streams use valid/ready: a transfer happens on a rising clock edge where valid and ready are
// both 1. A source holds valid and its payload steady until that edge. Ready may change freely.
interface ofmap_stream_if #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 16,
  parameter int XY_W   = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                   in_valid;
  logic                   in_sof;
  logic [N_CH*DATA_W-1:0] in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_ch;
  logic [XY_W-1:0]        out_x;
  logic [XY_W-1:0]        out_y;
  logic                   out_sof;
  logic                   out_eol;
  logic                   out_eof;
  logic                   frame_done;
  logic                   overflow;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_x, out_y,
           out_sof, out_eol, out_eof, frame_done, overflow
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_x, out_y,
           out_sof, out_eol, out_eof, frame_done, overflow
  );
endinterface

// File: rtl/ofmap_stream_collector.sv
// Buffers N_CH-wide output-pixel vectors in a small FIFO and serialises them one channel word
// per cycle, tagged with channel index, pixel coordinates and frame/row markers.
module ofmap_stream_collector #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 16,
  parameter int DEPTH  = 4,
  parameter int COLS   = 3,
  parameter int ROWS   = 3,
  parameter int XY_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  ofmap_stream_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CH_W = $clog2(N_CH);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [XY_W-1:0] X_LAST   = XY_W'(COLS - 1);
  localparam logic [XY_W-1:0] Y_LAST   = XY_W'(ROWS - 1);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

  logic [N_CH*DATA_W-1:0] mem_data_q [DEPTH];
  logic [DEPTH-1:0]       mem_sof_q;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [XY_W-1:0]        x_q, x_d, y_q, y_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_done_q, frame_done_d;

  logic                   full, empty, push, accept, pop;
  logic                   head_sof, last_ch, last_x, last_y, eol, eof;
  logic [XY_W-1:0]        cur_x, cur_y;
  logic [N_CH*DATA_W-1:0] head_data;

  always_comb begin
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    head_data = mem_data_q[rd_ptr_q];
    head_sof  = mem_sof_q[rd_ptr_q] & ~empty;
    // A sof-tagged head overrides the running pixel counters, restarting the frame at (0,0).
    cur_x     = head_sof ? '0 : x_q;
    cur_y     = head_sof ? '0 : y_q;
    last_ch   = (ch_q == CH_LAST);
    last_x    = (cur_x == X_LAST);
    last_y    = (cur_y == Y_LAST);
    eol       = ~empty & last_ch & last_x;
    eof       = eol & last_y;
    push      = bus.in_valid & ~full;
    accept    = ~empty & bus.out_ready;
    pop       = accept & last_ch;

    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q;
    ch_d         = ch_q;
    x_d          = x_q;
    y_d          = y_q;
    overflow_d   = overflow_q | (bus.in_valid & full);
    frame_done_d = accept & eof;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (accept) ch_d = last_ch ? '0 : ch_q + 1'b1;

    if (pop) begin
      x_d = last_x ? '0 : cur_x + 1'b1;
      y_d = last_x ? (last_y ? '0 : cur_y + 1'b1) : cur_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ch_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ch_q         <= ch_d;
      x_q          <= x_d;
      y_q          <= y_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= bus.in_data;
      mem_sof_q[wr_ptr_q]  <= bus.in_sof;
    end
  end

  assign bus.in_ready   = ~full;
  assign bus.out_valid  = ~empty;
  assign bus.out_data   = empty ? '0 : head_data[ch_q*DATA_W +: DATA_W];
  assign bus.out_ch     = ch_q;
  assign bus.out_x      = cur_x;
  assign bus.out_y      = cur_y;
  assign bus.out_sof    = head_sof & (ch_q == '0);
  assign bus.out_eol    = eol;
  assign bus.out_eof    = eof;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
endmodule
